transform_scaler: RTL and testbench
===================================

Name: transform_scaler

Overview:
- Successor to the single-shot `transform` coordinate mapper.
- Maps a screen pixel (x, y) into canvas coordinates normalised to a template rectangle with origin (x0, y0) and size t_width × t_height: cv = ((p − p0) << SCALE_SH) / t_size, per axis.
- Parametrised widths and scale, start/busy/done handshake, range and error flags.
- Uses one shared sequential divider (no combinational divide); sits between the tracking logic and the canvas renderer.

Parameters:
- XW, 11, x/x0/t_width width; must be ≥ YW.
- YW, 10, y/y0/t_height width.
- OW, 13, cv_x/cv_y width.
- SCALE_SH, 8, fractional scale shift; canvas units per template = 2^SCALE_SH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- x  in  XW  pixel x.
- y  in  YW  pixel y.
- x0  in  XW  template origin x.
- y0  in  YW  template origin y.
- t_width  in  XW  template width.
- t_height  in  YW  template height.
- busy  out  1  operation in progress.
- done  out  1  one-cycle result-valid pulse.
- cv_x  out  OW  scaled x.
- cv_y  out  OW  scaled y.
- oor  out  1  point outside template (valid with done).
- err  out  1  zero-size template (valid with done).

Behaviour:
- Reset (async, any state) → IDLE; busy=0, done=0, cv_x=0, cv_y=0, oor=0, err=0; an in-flight division is discarded.
- N = XW+SCALE_SH (19 by default): divider dividend width and iteration count, 1 quotient bit/cycle.
- States:
  - IDLE: start=1 latches all inputs, → CHECK; busy=1 from the next cycle.
  - CHECK (1 cycle): computes dx=x−x0 and dy=y−y0.
    - If x<x0: dx=0, oor set. Same rule for y<y0.
    - If dx≥t_width or dy≥t_height: oor set, value still computed.
    - If t_width==0 or t_height==0: err=1, cv_x=cv_y=0, → DONE.
    - Otherwise → DIV_X.
  - DIV_X (N cycles): divider computes (dx<<SCALE_SH)/t_width, → DIV_Y.
  - DIV_Y (N cycles): divider computes (dy<<SCALE_SH)/t_height, zero-extended to N bits, → DONE.
  - DONE (1 cycle): done=1, busy=1; cv_x, cv_y, oor, err update on entry to DONE. → IDLE.
- Latency: done asserts 2N+2 cycles after the start-sampling edge (40 by default); error path takes 2 cycles.
- Saturation: a quotient ≥ 2^OW drives the output to 2^OW−1.
- Outputs hold their last result until the next DONE.
- start while busy=1: ignored, no queueing.
- start during the DONE cycle: ignored; start is accepted in IDLE on the following cycle.
- Inputs may change freely after the sampling edge; only latched copies are used.

Optional Feature:
- TRANSFORM_ROUND_EN defined: dividend becomes (d<<SCALE_SH) + (divisor>>1), i.e. round-half-up instead of floor. Latency is unchanged; the dividend is widened one bit internally if needed.
- Undefined: truncating (floor) division.

Decomposition:
- transform_pkg holds:
  - state enum (IDLE, CHECK, DIV_X, DIV_Y, DONE);
  - localparam derivations N and saturation constant;
  - default width constants shared with the renderer.
- One sub-module: seq_divider.
  - Parameters: dividend width N, divisor width XW.
  - Ports: clk/reset/go/dividend/divisor → quotient/rdy.
  - Unsigned restoring algorithm, exactly N cycles.
- transform_scaler instantiates seq_divider once and time-shares it between the axes.

Test Plan:
- Nominal: x0=200, y0=300, t_width=80, t_height=80, x=230, y=340, start 1 cycle → done exactly 40 cycles later; cv_x=96, cv_y=128, oor=0, err=0.
- Zero size: t_width=0, other inputs as nominal → done 2 cycles after start; cv_x=cv_y=0, err=1.
- Out of range / saturation:
  - x=100, x0=200 → cv_x=0, oor=1.
  - x=2047, x0=0, t_width=1 → cv_x=8191 (saturated), oor=1.
- Rounding: dx=2, t_width=3 → cv_x=170 without the macro; 171 with TRANSFORM_ROUND_EN.
- Handshake: start re-pulsed at cycles 5 and 39 of a busy operation → ignored, single done. Back-to-back start on the cycle after done → second result correct, busy low for exactly one cycle.
- Reset mid-DIV_Y (cycle 30) → all outputs 0 and busy=0 immediately (asynchronous); a fresh start then yields the nominal result.

Source files
------------

// File: rtl/transform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transform_pkg
//  Description : Shared types and constants for the transform_scaler block
//                and the canvas renderer: FSM state encoding, default port
//                widths, derived divider length and saturation value.
//  Revision    : 1.0 - initial release
// ============================================================================
package transform_pkg;

  // Default widths shared with the canvas renderer
  localparam int DEF_XW       = 11;
  localparam int DEF_YW       = 10;
  localparam int DEF_OW       = 13;
  localparam int DEF_SCALE_SH = 8;

  // Divider dividend width == iteration count (one quotient bit per cycle)
  localparam int DEF_N   = DEF_XW + DEF_SCALE_SH;
  // Largest representable canvas coordinate; larger quotients clamp here
  localparam int DEF_SAT = (1 << DEF_OW) - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/transform_scaler_if.sv
`default_nettype none
// ============================================================================
//  Module      : transform_scaler_if
//  Description : Request/result bundle of transform_scaler.
//                master : drives start, x, y, x0, y0, t_width, t_height;
//                         receives busy, done, cv_x, cv_y, oor, err.
//                slave  : the scaler itself (opposite directions).
//  Revision    : 1.0 - initial release
// ============================================================================
interface transform_scaler_if
  import transform_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW,
  parameter int OW = DEF_OW
);
  logic          start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW-1:0] t_width;
  logic [YW-1:0] t_height;
  logic          busy;
  logic          done;
  logic [OW-1:0] cv_x;
  logic [OW-1:0] cv_y;
  logic          oor;
  logic          err;

  modport master (
    output start, x, y, x0, y0, t_width, t_height,
    input  busy, done, cv_x, cv_y, oor, err
  );

  modport slave (
    input  start, x, y, x0, y0, t_width, t_height,
    output busy, done, cv_x, cv_y, oor, err
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Unsigned restoring divider, one quotient bit per cycle,
//                exactly N cycles from the go edge to rdy.
//                The go edge itself performs the first iteration, so the
//                quotient is valid (rdy=1) after N rising edges counting
//                the go edge. Bits of dividend above N (DW > N) preload the
//                partial remainder; the caller guarantees that value is
//                smaller than the divisor.
//  Ports       : clk, reset (async, active-high)
//                go       - load operands and start
//                dividend - DW bits, divisor - XW bits (non-zero)
//                quotient - N bits, rdy - result valid / divider idle
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int N  = 19,
  parameter int XW = 11,
  parameter int DW = N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [DW-1:0] dividend,
  input  logic [XW-1:0] divisor,
  output logic [N-1:0]  quotient,
  output logic          rdy
);
  localparam int CW = $clog2(N + 1);

  logic [XW-1:0] r_rem;
  logic [N-1:0]  r_quo;
  logic [XW-1:0] r_dvs;
  logic [CW-1:0] r_cnt;

  logic [XW-1:0] w_rem_init;
  logic [XW-1:0] w_rem_src;
  logic [N-1:0]  w_quo_src;
  logic [XW-1:0] w_dvs_src;
  logic [XW:0]   w_shift;
  logic [XW:0]   w_trial;
  logic          w_fits;
  logic [XW-1:0] w_rem_next;
  logic [N-1:0]  w_quo_next;

  generate
    if (DW > N) begin : g_hi
      assign w_rem_init = XW'(dividend[DW-1:N]);
    end else begin : g_nohi
      assign w_rem_init = '0;
    end
  endgenerate

  // One restoring step; on go it works straight from the new operands
  always_comb begin
    w_rem_src  = go ? w_rem_init : r_rem;
    w_quo_src  = go ? dividend[N-1:0] : r_quo;
    w_dvs_src  = go ? divisor : r_dvs;
    w_shift    = {w_rem_src, w_quo_src[N-1]};
    w_trial    = w_shift - {1'b0, w_dvs_src};
    w_fits     = (w_shift >= {1'b0, w_dvs_src});
    w_rem_next = w_fits ? w_trial[XW-1:0] : w_shift[XW-1:0];
    w_quo_next = {w_quo_src[N-2:0], w_fits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= CW'(N);
    end else if (go) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_dvs <= divisor;
      r_cnt <= CW'(1);
    end else if (r_cnt != CW'(N)) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign quotient = r_quo;
  assign rdy      = (r_cnt == CW'(N));

endmodule
`default_nettype wire

// File: rtl/transform_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : transform_scaler
//  Description : Maps a screen pixel (x, y) into canvas coordinates
//                normalised to a template rectangle:
//                  cv = ((p - p0) << SCALE_SH) / t_size   per axis
//                using one time-shared sequential divider.
//                Optional build macro TRANSFORM_ROUND_EN selects
//                round-half-up instead of floor division.
//  Ports       : clk, reset (async, active-high)
//                bus (transform_scaler_if.slave):
//                  start, x, y, x0, y0, t_width, t_height  -> request
//                  busy, done, cv_x, cv_y, oor, err        -> status/result
//  Revision    : 1.0 - initial release
// ============================================================================
module transform_scaler
  import transform_pkg::*;
#(
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int OW       = DEF_OW,
  parameter int SCALE_SH = DEF_SCALE_SH
) (
  input  logic                clk,
  input  logic                reset,
  transform_scaler_if.slave   bus
);
  localparam int N = XW + SCALE_SH;
`ifdef TRANSFORM_ROUND_EN
  // Room for the half-divisor carry out of the N-bit shifted dividend
  localparam int DW = N + 1;
`else
  localparam int DW = N;
`endif
  localparam logic [OW-1:0] SAT_OW = {OW{1'b1}};
  localparam logic [N-1:0]  SAT_N  = {{(N-OW){1'b0}}, SAT_OW};

  state_t r_state;
  state_t w_state_next;

  // Latched request
  logic [XW-1:0] r_x, r_x0, r_tw;
  logic [YW-1:0] r_y, r_y0, r_th;

  // Per-operation working values
  logic [YW-1:0] r_dy;
  logic          r_oor;
  logic [N-1:0]  r_qx;

  // Result registers
  logic [OW-1:0] r_cv_x, r_cv_y;
  logic          r_oor_o, r_err_o;

  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic          w_oor;
  logic          w_err;
  logic [DW-1:0] w_num_x, w_num_y;

  logic          w_busy, w_done;
  logic          w_div_go;
  logic [DW-1:0] w_div_dividend;
  logic [XW-1:0] w_div_divisor;
  logic [N-1:0]  w_div_q;
  logic          w_div_rdy;

  function automatic logic [OW-1:0] f_sat(input logic [N-1:0] q);
    if (q > SAT_N) f_sat = SAT_OW;
    else           f_sat = q[OW-1:0];
  endfunction

  // Offsets clamp at zero when the point lies left of / above the template
  always_comb begin
    w_dx  = (r_x < r_x0) ? '0 : (r_x - r_x0);
    w_dy  = (r_y < r_y0) ? '0 : (r_y - r_y0);
    w_oor = (r_x < r_x0) || (r_y < r_y0) || (w_dx >= r_tw) || (w_dy >= r_th);
    w_err = (r_tw == '0) || (r_th == '0);
  end

  always_comb begin
    w_num_x = DW'(w_dx) << SCALE_SH;
    w_num_y = DW'(r_dy) << SCALE_SH;
`ifdef TRANSFORM_ROUND_EN
    w_num_x = w_num_x + DW'(r_tw >> 1);
    w_num_y = w_num_y + DW'(r_th >> 1);
`endif
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = CHECK;
      CHECK:   w_state_next = w_err ? DONE : DIV_X;
      DIV_X:   if (w_div_rdy) w_state_next = DIV_Y;
      DIV_Y:   if (w_div_rdy) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The x division is launched on the CHECK->DIV_X edge from the live
  // offset; the y division is launched on the DIV_X->DIV_Y edge.
  always_comb begin
    w_busy         = (r_state != IDLE);
    w_done         = (r_state == DONE);
    w_div_go       = 1'b0;
    w_div_dividend = w_num_y;
    w_div_divisor  = XW'(r_th);
    case (r_state)
      CHECK: begin
        w_div_go       = !w_err;
        w_div_dividend = w_num_x;
        w_div_divisor  = r_tw;
      end
      DIV_X:   w_div_go = w_div_rdy;
      default: ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_x0    <= '0;
      r_tw    <= '0;
      r_y     <= '0;
      r_y0    <= '0;
      r_th    <= '0;
      r_dy    <= '0;
      r_oor   <= 1'b0;
      r_qx    <= '0;
      r_cv_x  <= '0;
      r_cv_y  <= '0;
      r_oor_o <= 1'b0;
      r_err_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_x  <= bus.x;
            r_x0 <= bus.x0;
            r_tw <= bus.t_width;
            r_y  <= bus.y;
            r_y0 <= bus.y0;
            r_th <= bus.t_height;
          end
        end
        CHECK: begin
          r_dy  <= w_dy;
          r_oor <= w_oor;
          if (w_err) begin
            r_cv_x  <= '0;
            r_cv_y  <= '0;
            r_oor_o <= w_oor;
            r_err_o <= 1'b1;
          end
        end
        DIV_X: begin
          if (w_div_rdy) r_qx <= w_div_q;
        end
        DIV_Y: begin
          if (w_div_rdy) begin
            r_cv_x  <= f_sat(r_qx);
            r_cv_y  <= f_sat(w_div_q);
            r_oor_o <= r_oor;
            r_err_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .N  (N),
    .XW (XW),
    .DW (DW)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (w_div_go),
    .dividend (w_div_dividend),
    .divisor  (w_div_divisor),
    .quotient (w_div_q),
    .rdy      (w_div_rdy)
  );

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.cv_x = r_cv_x;
  assign bus.cv_y = r_cv_y;
  assign bus.oor  = r_oor_o;
  assign bus.err  = r_err_o;

endmodule
`default_nettype wire

// File: tb/tb_transform_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transform_scaler
//  Description : Directed self-checking bench for transform_scaler with
//                hand-computed expected values. Honours TRANSFORM_ROUND_EN
//                for the rounding vector. Cycle numbering: cycle 1 is the
//                cycle following the edge that samples start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transform_scaler;
  import transform_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec;
  int   n_miscmp;

  always #5 clk = ~clk;

  transform_scaler_if bus ();

  transform_scaler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef TRANSFORM_ROUND_EN
  localparam int EXP_ROUND = 171;   // (512 + 1) / 3
`else
  localparam int EXP_ROUND = 170;   // 512 / 3
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input int x, input int y, input int x0, input int y0,
                        input int tw, input int th);
    bus.x        = 11'(x);
    bus.y        = 10'(y);
    bus.x0       = 11'(x0);
    bus.y0       = 10'(y0);
    bus.t_width  = 11'(tw);
    bus.t_height = 10'(th);
  endtask

  // Pulse start for one edge; inputs must already be set.
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns the cycle number in which done is seen (0 on timeout);
  // returns at the falling edge inside the DONE cycle.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input int x, input int y, input int x0, input int y0,
                        input int tw, input int th, output int lat);
    set_in(x, y, x0, y0, tw, th);
    pulse_start();
    wait_done(lat);
  endtask

  int lat;
  int n_done, first_done, second_done, busy_low;
  logic [12:0] cvx_seen, cvy_seen;

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    reset    = 1'b0;
    bus.start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_cv_x", bus.cv_x, 0);
    check_eq("rst_cv_y", bus.cv_y, 0);
    check_eq("rst_oor",  bus.oor,  0);
    check_eq("rst_err",  bus.err,  0);
    reset = 1'b0;

    // Nominal: dx=30, dy=40, size 80 -> 96, 128
    run_op(230, 340, 200, 300, 80, 80, lat);
    check_eq("nom_lat",  lat, 40);
    check_eq("nom_busy", bus.busy, 1);
    check_eq("nom_cv_x", bus.cv_x, 96);
    check_eq("nom_cv_y", bus.cv_y, 128);
    check_eq("nom_oor",  bus.oor, 0);
    check_eq("nom_err",  bus.err, 0);

    // Zero-width template
    run_op(230, 340, 200, 300, 0, 80, lat);
    check_eq("zero_lat",  lat, 2);
    check_eq("zero_cv_x", bus.cv_x, 0);
    check_eq("zero_cv_y", bus.cv_y, 0);
    check_eq("zero_err",  bus.err, 1);

    // Left of template: dx clamps to 0
    run_op(100, 340, 200, 300, 80, 80, lat);
    check_eq("left_lat",  lat, 40);
    check_eq("left_cv_x", bus.cv_x, 0);
    check_eq("left_cv_y", bus.cv_y, 128);
    check_eq("left_oor",  bus.oor, 1);
    check_eq("left_err",  bus.err, 0);

    // Saturation: 2047*256/1 = 524032 -> 8191
    run_op(2047, 340, 0, 300, 1, 80, lat);
    check_eq("sat_cv_x", bus.cv_x, 8191);
    check_eq("sat_cv_y", bus.cv_y, 128);
    check_eq("sat_oor",  bus.oor, 1);

    // Rounding: dx=2, width 3
    run_op(202, 340, 200, 300, 3, 80, lat);
    check_eq("rnd_cv_x", bus.cv_x, EXP_ROUND);
    check_eq("rnd_oor",  bus.oor, 0);

    // Stray starts at cycles 5, 39 and during DONE (40) are ignored
    set_in(230, 340, 200, 300, 80, 80);
    pulse_start();
    n_done = 0;
    first_done = 0;
    cvx_seen = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          cvx_seen = bus.cv_x;
        end
      end
      bus.start = (c == 5 || c == 39 || c == 40);
      if (c == 5) bus.x = 11'd100;
    end
    bus.start = 1'b0;
    check_eq("hs_first_done", first_done, 40);
    check_eq("hs_done_count", n_done, 1);
    check_eq("hs_cv_x", cvx_seen, 96);
    check_eq("hs_idle_busy", bus.busy, 0);
    check_eq("hs_hold_cv_x", bus.cv_x, 96);

    // Back-to-back: start in the cycle right after done
    set_in(230, 340, 200, 300, 80, 80);
    pulse_start();
    busy_low = 0;
    first_done = 0;
    second_done = 0;
    cvx_seen = '0;
    cvy_seen = '0;
    for (int c = 1; c <= 85; c++) begin
      @(negedge clk);
      if (bus.done && c <= 40) first_done = c;
      if (bus.done && c > 41 && second_done == 0) begin
        second_done = c;
        cvx_seen = bus.cv_x;
        cvy_seen = bus.cv_y;
      end
      if (c >= 41 && c <= 81 && !bus.busy) busy_low++;
      if (c == 41) begin
        set_in(260, 320, 200, 300, 80, 80);   // dx=60, dy=20 -> 192, 64
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check_eq("b2b_first_done", first_done, 40);
    check_eq("b2b_busy_low", busy_low, 1);
    check_eq("b2b_second_done", second_done, 81);
    check_eq("b2b_cv_x", cvx_seen, 192);
    check_eq("b2b_cv_y", cvy_seen, 64);

    // Asynchronous reset in the middle of DIV_Y
    set_in(230, 340, 200, 300, 80, 80);
    pulse_start();
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_done", bus.done, 0);
    check_eq("arst_cv_x", bus.cv_x, 0);
    check_eq("arst_cv_y", bus.cv_y, 0);
    check_eq("arst_oor",  bus.oor, 0);
    check_eq("arst_err",  bus.err, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(230, 340, 200, 300, 80, 80, lat);
    check_eq("post_rst_lat",  lat, 40);
    check_eq("post_rst_cv_x", bus.cv_x, 96);
    check_eq("post_rst_cv_y", bus.cv_y, 128);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
